hiscore_ram_bridge: RTL and testbench
=====================================

Name: hiscore_ram_bridge

Overview:
- Responder side of the hiscore RAM-access protocol, instantiated inside the game core next to the CPU work RAM.
- Services read/write intents from the hiscore engine: stalls the CPU, waits for in-flight CPU accesses to drain, then hands the work-RAM port to the hiscore engine.
- Returns RAM ownership to the CPU when both intents drop.
- Addresses outside the RAM window are answered harmlessly.

Parameters:
- RAM_BASE, 16'h6000, CPU address of the first work-RAM byte.
- RAM_AW, 11, work-RAM address width (window size 2**RAM_AW bytes).
- DRAIN_CYCLES, 8, clocks cpu_hold must be asserted before the bridge takes the RAM port. Must cover one full CPU bus cycle.

Ports:
- clock_12mhz  in  1  core clock
- reset  in  1  asynchronous, active-high
- cpu_addr  in  RAM_AW  CPU-side RAM address
- cpu_we  in  1  CPU-side RAM write strobe
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  RAM read data to CPU (combinational from ram_dout)
- cpu_hold  out  1  CPU stall request; ORed with pause into the CPU wait logic
- ram_addr  out  RAM_AW  to work-RAM port
- ram_we  out  1  to work-RAM port
- ram_din  out  8  to work-RAM port
- ram_dout  in  8  from work RAM; synchronous, 1-clock read latency
- hs_address  in  16  hiscore CPU-space address
- hs_data_in  in  8  hiscore write data
- hs_write_enable  in  1  hiscore write strobe, one clock per byte
- hs_read_intent  in  1  hiscore wants read access
- hs_write_intent  in  1  hiscore wants write access
- hs_data_out  out  8  read data to hiscore
- hs_granted  out  1  high while the bridge owns the RAM port

Behaviour:
- States: IDLE, DRAIN, OWN, RELEASE. Reset (async) forces IDLE.
- Reset values: cpu_hold=0, hs_granted=0, hs_data_out=8'h00, drain counter=0. RAM port muxed to the CPU.
- intent = hs_read_intent | hs_write_intent.
- IDLE:
  - RAM port = CPU signals; cpu_hold=0.
  - intent=1 -> DRAIN, counter loaded with DRAIN_CYCLES-1.
- DRAIN:
  - cpu_hold=1; RAM port still CPU (a finishing CPU write must land).
  - Counter decrements each clock; at 0 -> OWN.
  - If intent drops during DRAIN -> RELEASE.
- OWN:
  - cpu_hold=1, hs_granted=1.
  - in_win = (hs_address - RAM_BASE) < 2**RAM_AW, using 16-bit unsigned subtract; wrap below RAM_BASE is out of window.
  - ram_addr = (hs_address - RAM_BASE)[RAM_AW-1:0].
  - ram_we = hs_write_enable & in_win; ram_din = hs_data_in.
  - hs_data_out registered every clock: ram_dout if in_win was true on the previous clock, else 8'h00.
  - Read result is valid 2 clocks after hs_address is stable.
  - Out-of-window writes are dropped; RAM is untouched.
  - intent=0 -> RELEASE.
- RELEASE:
  - RAM port returns to CPU; hs_granted=0; cpu_hold held 1 for this one clock -> IDLE.
  - Intent reasserted here is not accepted until IDLE, so re-entry costs a full drain.
- hs_write_enable outside OWN is ignored: ram_we follows cpu_we only.
- cpu_we during DRAIN passes through; during OWN/RELEASE-to-OWN it is ignored, since the CPU is held.
- hs_data_out keeps its last value outside OWN.
- Async reset in any state: immediate IDLE, cpu_hold=0, no RAM write issued on that clock.
- No combinational path from hs_* inputs to cpu_hold.

Test Plan:
- CPU passthrough: in IDLE, cpu_addr=0x123, cpu_we=1, cpu_din=0x5A -> ram_addr=0x123, ram_we=1, ram_din=0x5A; cpu_hold=0, hs_granted=0 throughout.
- Read handshake: assert hs_read_intent, hs_address=0x6010, RAM[0x010]=0xA7 -> cpu_hold rises next clock, hs_granted rises exactly 8 clocks later, hs_data_out=0xA7 two clocks after grant.
- Write: in OWN, hs_address=0x6100, hs_data_in=0x3C, one-clock hs_write_enable -> ram_addr=0x100, ram_we=1 for exactly one clock; readback returns 0x3C.
- Out-of-window: hs_address=0x5FFF and 0x6800, write 0xFF then read -> ram_we stays 0, hs_data_out=0x00, RAM contents unchanged.
- Release: drop both intents in OWN -> hs_granted=0 next clock, cpu_hold=0 one clock after that. Drop intent mid-DRAIN -> never granted, cpu_hold released through RELEASE.
- Reset mid-OWN with hs_write_enable=1 -> outputs at reset values immediately, no RAM write; a subsequent intent re-runs the full 8-clock drain.

Source files
------------

// File: rtl/hiscore_ram_bridge.sv
// Responder side of the hiscore RAM-access protocol: stalls the CPU, drains its
// in-flight bus cycle, then lends the work-RAM port to the hiscore engine.
module hiscore_ram_bridge #(
   parameter logic [15:0] RAM_BASE     = 16'h6000,
   parameter int unsigned RAM_AW       = 11,
   parameter int unsigned DRAIN_CYCLES = 8
) (
   input  logic              clock_12mhz,
   input  logic              reset,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_hold,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout,
   input  logic [15:0]       hs_address,
   input  logic [7:0]        hs_data_in,
   input  logic              hs_write_enable,
   input  logic              hs_read_intent,
   input  logic              hs_write_intent,
   output logic [7:0]        hs_data_out,
   output logic              hs_granted
);

   localparam int unsigned CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [16:0] WIN_SIZE = 17'(2 ** RAM_AW);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      OWN,
      RELEASE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              intent;
   logic [15:0]       offset;
   logic              in_win;
   logic              in_win_q;

   assign intent   = hs_read_intent | hs_write_intent;
   assign cpu_dout = ram_dout;

   // Addresses below RAM_BASE wrap to large offsets and fall outside the window.
   assign offset = hs_address - RAM_BASE;
   assign in_win = {1'b0, offset} < WIN_SIZE;

   always_ff @(posedge clock_12mhz or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (intent) begin
               state_next = DRAIN;
               cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            if (!intent) begin
               state_next = RELEASE;
            end else if (cnt == '0) begin
               state_next = OWN;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         OWN: begin
            if (!intent) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // RAM port belongs to the CPU except while owned; reset suppresses any write.
   always_comb begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      ram_din  = cpu_din;
      if (state == OWN) begin
         ram_addr = offset[RAM_AW-1:0];
         ram_we   = hs_write_enable & in_win;
         ram_din  = hs_data_in;
      end
      if (reset) begin
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge clock_12mhz or posedge reset) begin
      if (reset) begin
         cpu_hold    <= 1'b0;
         hs_granted  <= 1'b0;
         hs_data_out <= 8'h00;
         in_win_q    <= 1'b0;
      end else begin
         cpu_hold   <= (state_next != IDLE);
         hs_granted <= (state_next == OWN);
         in_win_q   <= (state == OWN) & in_win;
         if (state == OWN) begin
            hs_data_out <= in_win_q ? ram_dout : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_hiscore_ram_bridge.sv
// Scoreboard bench for hiscore_ram_bridge: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_hiscore_ram_bridge;

   localparam int S_HOLD  = 0;
   localparam int S_GNT   = 1;
   localparam int S_HSD   = 2;
   localparam int S_RADDR = 3;
   localparam int S_RWE   = 4;
   localparam int S_RDIN  = 5;
   localparam int S_MEM   = 6;
   localparam int S_CDOUT = 7;

   typedef struct {
      int          cyc;
      int          sig;
      logic [10:0] addr;
      logic [15:0] val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_hold;
   logic [10:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [15:0] hs_address;
   logic [7:0]  hs_data_in;
   logic        hs_write_enable;
   logic        hs_read_intent;
   logic        hs_write_intent;
   logic [7:0]  hs_data_out;
   logic        hs_granted;

   logic [7:0]  mem [0:2047];
   logic        preload;
   logic        done;
   int          cyc = 0;
   exp_t        sb[$];
   int          passed = 0;
   int          total = 0;
   logic [15:0] got;

   hiscore_ram_bridge dut (
      .clock_12mhz     (clk),
      .reset           (reset),
      .cpu_addr        (cpu_addr),
      .cpu_we          (cpu_we),
      .cpu_din         (cpu_din),
      .cpu_dout        (cpu_dout),
      .cpu_hold        (cpu_hold),
      .ram_addr        (ram_addr),
      .ram_we          (ram_we),
      .ram_din         (ram_din),
      .ram_dout        (ram_dout),
      .hs_address      (hs_address),
      .hs_data_in      (hs_data_in),
      .hs_write_enable (hs_write_enable),
      .hs_read_intent  (hs_read_intent),
      .hs_write_intent (hs_write_intent),
      .hs_data_out     (hs_data_out),
      .hs_granted      (hs_granted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-first synchronous work RAM with one clock of read latency.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
         mem[11'h010] <= 8'hA7;
         mem[11'h100] <= 8'h11;
         mem[11'h7FF] <= 8'h42;
         mem[11'h000] <= 8'h24;
         mem[11'h200] <= 8'h77;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      ram_dout <= mem[ram_addr];
   end

   function automatic logic [15:0] sample(input int sig, input logic [10:0] a);
      case (sig)
         S_HOLD:  return 16'(cpu_hold);
         S_GNT:   return 16'(hs_granted);
         S_HSD:   return 16'(hs_data_out);
         S_RADDR: return 16'(ram_addr);
         S_RWE:   return 16'(ram_we);
         S_RDIN:  return 16'(ram_din);
         S_MEM:   return 16'(mem[a]);
         S_CDOUT: return 16'(cpu_dout);
         default: return 16'hDEAD;
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            got = sample(sb[i].sig, sb[i].addr);
            total++;
            if (got === sb[i].val) passed++;
            else $display("FAIL %s cycle=%0d got=%h expected=%h", sb[i].name, cyc, got, sb[i].val);
            sb.delete(i);
         end
      end
      if (done) begin
         foreach (sb[i]) begin
            total++;
            $display("FAIL %s never sampled (cycle %0d)", sb[i].name, sb[i].cyc);
         end
         $display("%0d/%0d checks passed", passed, total);
         $finish;
      end
   end

   task automatic want(input int dly, input int sig, input logic [15:0] val, input string nm,
                       input logic [10:0] a = 11'h000);
      exp_t e;
      e.cyc  = cyc + dly;
      e.sig  = sig;
      e.addr = a;
      e.val  = val;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic steps(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; preload = 1'b1; done = 1'b0;
      cpu_addr = '0; cpu_we = 1'b0; cpu_din = '0;
      hs_address = '0; hs_data_in = '0; hs_write_enable = 1'b0;
      hs_read_intent = 1'b0; hs_write_intent = 1'b0;
      steps(1);
      preload = 1'b0;
      want(0, S_HOLD, 16'h0, "rst_hold");
      want(0, S_GNT,  16'h0, "rst_gnt");
      want(0, S_HSD,  16'h0, "rst_hsd");
      steps(1);
      reset = 1'b0;

      // CPU passthrough in IDLE
      cpu_addr = 11'h123; cpu_we = 1'b1; cpu_din = 8'h5A;
      want(0, S_RADDR, 16'h123, "pt_addr");
      want(0, S_RWE,   16'h1,   "pt_we");
      want(0, S_RDIN,  16'h5A,  "pt_din");
      want(0, S_HOLD,  16'h0,   "pt_hold");
      want(0, S_GNT,   16'h0,   "pt_gnt");
      want(1, S_MEM,   16'h5A,  "pt_mem", 11'h123);
      want(2, S_CDOUT, 16'h5A,  "pt_cdout");
      steps(1);
      cpu_we = 1'b0;
      want(0, S_HOLD, 16'h0, "pt_hold2");
      steps(2);

      // Read handshake: 8-clock drain, data two clocks after grant
      hs_read_intent = 1'b1; hs_address = 16'h6010;
      want(0,  S_HOLD,  16'h0,   "rd_hold_pre");
      want(1,  S_HOLD,  16'h1,   "rd_hold_rise");
      want(1,  S_GNT,   16'h0,   "rd_gnt_early");
      want(8,  S_GNT,   16'h0,   "rd_gnt_last_drain");
      want(9,  S_GNT,   16'h1,   "rd_gnt_rise");
      want(9,  S_RADDR, 16'h010, "rd_raddr");
      want(10, S_HSD,   16'h00,  "rd_hsd_lat");
      want(11, S_HSD,   16'hA7,  "rd_hsd");
      steps(11);

      // Single-byte write in OWN, then readback
      hs_address = 16'h6100; hs_data_in = 8'h3C; hs_write_enable = 1'b1;
      want(0, S_RADDR, 16'h100, "wr_raddr");
      want(0, S_RWE,   16'h1,   "wr_we");
      want(0, S_RDIN,  16'h3C,  "wr_din");
      want(1, S_RWE,   16'h0,   "wr_we_pulse");
      want(1, S_MEM,   16'h3C,  "wr_mem", 11'h100);
      want(2, S_HSD,   16'h11,  "wr_old_data");
      want(3, S_HSD,   16'h3C,  "wr_readback");
      steps(1);
      hs_write_enable = 1'b0;
      steps(2);

      // Out-of-window below the base, above the top, and the last in-window byte
      hs_address = 16'h5FFF; hs_data_in = 8'hFF; hs_write_enable = 1'b1;
      want(0, S_RWE,   16'h0,   "oow_lo_we");
      want(0, S_RADDR, 16'h7FF, "oow_lo_addr");
      want(1, S_MEM,   16'h42,  "oow_lo_mem", 11'h7FF);
      want(2, S_HSD,   16'h00,  "oow_lo_rd");
      steps(1);
      hs_write_enable = 1'b0;
      steps(1);
      hs_address = 16'h6800; hs_write_enable = 1'b1;
      want(0, S_RWE,   16'h0,   "oow_hi_we");
      want(0, S_RADDR, 16'h000, "oow_hi_addr");
      want(1, S_MEM,   16'h24,  "oow_hi_mem", 11'h000);
      want(2, S_HSD,   16'h00,  "oow_hi_rd");
      steps(1);
      hs_write_enable = 1'b0;
      steps(1);
      hs_address = 16'h67FF;
      want(2, S_HSD, 16'h42, "win_top_rd");
      steps(3);

      // Release from OWN; read data holds afterwards
      hs_read_intent = 1'b0;
      want(0, S_GNT,  16'h1,  "rel_gnt_pre");
      want(1, S_GNT,  16'h0,  "rel_gnt_drop");
      want(1, S_HOLD, 16'h1,  "rel_hold");
      want(2, S_HOLD, 16'h0,  "rel_hold_drop");
      want(2, S_HSD,  16'h42, "rel_hsd_keep");
      steps(3);

      // Intent dropped mid-drain; CPU write still passes through during drain
      hs_write_intent = 1'b1;
      for (int k = 1; k <= 12; k++) want(k, S_GNT, 16'h0, "abort_no_gnt");
      want(4, S_HOLD, 16'h1, "abort_release_hold");
      want(5, S_HOLD, 16'h0, "abort_idle_hold");
      steps(1);
      cpu_addr = 11'h055; cpu_din = 8'h99; cpu_we = 1'b1;
      want(0, S_RWE,   16'h1,   "drain_cpu_we");
      want(0, S_RADDR, 16'h055, "drain_cpu_addr");
      steps(1);
      cpu_we = 1'b0;
      steps(1);
      hs_write_intent = 1'b0;
      steps(10);

      // Reset while owning with a write strobe; then a full re-drain
      hs_write_intent = 1'b1; hs_address = 16'h6200; hs_data_in = 8'hEE;
      want(9,  S_GNT, 16'h1,  "r2_gnt");
      want(11, S_HSD, 16'h77, "r2_pre_rd");
      steps(12);
      hs_write_enable = 1'b1; reset = 1'b1;
      want(0, S_HOLD, 16'h0, "mrst_hold");
      want(0, S_GNT,  16'h0, "mrst_gnt");
      want(0, S_HSD,  16'h0, "mrst_hsd");
      want(0, S_RWE,  16'h0, "mrst_we");
      steps(1);
      reset = 1'b0; hs_write_enable = 1'b0;
      want(0, S_MEM,  16'h77, "mrst_mem", 11'h200);
      want(1, S_HOLD, 16'h1,  "redrain_hold");
      want(8, S_GNT,  16'h0,  "redrain_gnt_early");
      want(9, S_GNT,  16'h1,  "redrain_gnt");
      steps(10);
      hs_write_intent = 1'b0;
      steps(3);
      done = 1'b1;
      steps(5);
      $display("FAIL monitor did not finish");
      $fatal(1);
   end

endmodule
